mem_write_checker: RTL and testbench



---
 rtl/mem_write_checker_if.sv | 12 +
 rtl/mem_write_checker.sv | 158 +++++++++++++++
 tb/tb_mem_write_checker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_checker_if.sv
// Data-memory write port of the single-cycle core, as seen by the end-of-test checker.
interface mem_write_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_write;
    logic [ADDR_W-1:0] data_adr;
    logic [DATA_W-1:0] write_data;

    modport master (output mem_write, data_adr, write_data);
    modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/mem_write_checker.sv
// End-of-test checker: matches the core's memory writes, in order, against a table of
// expected (address, data) pairs and reports pass, mismatch or timeout.
module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter bit STRICT  = 1'b1,
    localparam int PW = $clog2(DEPTH + 1),
    localparam int CW = $clog2(TIMEOUT + 1),
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_write_checker_if.slave  bus,
    input  logic                exp_we,
    input  logic [IW-1:0]       exp_idx,
    input  logic [ADDR_W-1:0]   exp_adr,
    input  logic [DATA_W-1:0]   exp_data,
    input  logic [PW-1:0]       n_exp,
    input  logic                start,
    input  logic                clear,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          fail_code,
    output logic [PW-1:0]       match_cnt,
    output logic [CW-1:0]       cycles,
    output logic [ADDR_W-1:0]   fail_adr,
    output logic [DATA_W-1:0]   fail_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t            state;
    logic [PW-1:0]     n_lat;
    logic [ADDR_W-1:0] tbl_adr  [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];

    logic [PW-1:0]     n_clamped;
    logic              idx_ok;
    logic [IW-1:0]     ptr;
    logic              hit;
    logic              miss;
    logic [PW-1:0]     match_next;
    logic [CW-1:0]     cycles_next;
    logic              timeout_hit;

    // match_cnt never reaches DEPTH while in RUN, so its low bits always select a valid entry
    always_comb begin
        n_clamped   = (32'(n_exp) > DEPTH) ? PW'(DEPTH) : n_exp;
        idx_ok      = 32'(exp_idx) < DEPTH;
        ptr         = match_cnt[IW-1:0];
        hit         = bus.mem_write && (bus.data_adr == tbl_adr[ptr])
                                    && (bus.write_data == tbl_data[ptr]);
        miss        = bus.mem_write && !hit;
        match_next  = match_cnt + PW'(1);
        cycles_next = (cycles == CW'(TIMEOUT)) ? cycles : cycles + CW'(1);
        timeout_hit = (cycles == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            n_lat     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
            match_cnt <= '0;
            cycles    <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_adr[i]  <= '0;
                tbl_data[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exp_we && idx_ok) begin
                        tbl_adr[exp_idx]  <= exp_adr;
                        tbl_data[exp_idx] <= exp_data;
                    end
                    if (start) begin
                        n_lat     <= n_clamped;
                        match_cnt <= '0;
                        cycles    <= '0;
                        fail_code <= 2'd0;
                        fail_adr  <= '0;
                        fail_data <= '0;
                        if (n_clamped == '0) begin
                            state <= ST_PASS;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                // Completion outranks a mismatch, which outranks a timeout in the same cycle
                ST_RUN: begin
                    cycles <= cycles_next;
                    if (hit) begin
                        match_cnt <= match_next;
                    end
                    if (hit && (match_next == n_lat)) begin
                        state <= ST_PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (miss && STRICT) begin
                        state     <= ST_FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= 2'd1;
                        fail_adr  <= bus.data_adr;
                        fail_data <= bus.write_data;
                    end else if (timeout_hit) begin
                        state     <= ST_FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= 2'd2;
                    end
                end

                ST_PASS, ST_FAIL: begin
                    if (clear) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_code <= 2'd0;
                        match_cnt <= '0;
                        cycles    <= '0;
                        fail_adr  <= '0;
                        fail_data <= '0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: a strict and a lenient checker share one stimulus stream and are
// compared against hand-computed verdicts, counters and captured failure details.
module tb_mem_write_checker;

    localparam logic [5:0] F_IDLE = 6'b0000_00;
    localparam logic [5:0] F_RUN  = 6'b1000_00;
    localparam logic [5:0] F_PASS = 6'b0110_00;
    localparam logic [5:0] F_MISM = 6'b0101_01;
    localparam logic [5:0] F_TOUT = 6'b0101_10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        exp_we;
    logic [2:0]  exp_idx;
    logic [31:0] exp_adr;
    logic [31:0] exp_data;
    logic [3:0]  n_exp;
    logic        start;
    logic        clear;

    logic        a_busy, a_done, a_pass, a_fail;
    logic [1:0]  a_code;
    logic [3:0]  a_match;
    logic [4:0]  a_cycles;
    logic [31:0] a_fadr, a_fdata;
    logic        b_busy, b_done, b_pass, b_fail;
    logic [1:0]  b_code;
    logic [3:0]  b_match;
    logic [4:0]  b_cycles;
    logic [31:0] b_fadr, b_fdata;

    int checks   = 0;
    int failures = 0;

    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_write_checker #(.DEPTH(8), .TIMEOUT(16), .STRICT(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_if),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
        .n_exp(n_exp), .start(start), .clear(clear),
        .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
        .match_cnt(a_match), .cycles(a_cycles), .fail_adr(a_fadr), .fail_data(a_fdata)
    );

    mem_write_checker #(.DEPTH(8), .TIMEOUT(16), .STRICT(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_if),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
        .n_exp(n_exp), .start(start), .clear(clear),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
        .match_cnt(b_match), .cycles(b_cycles), .fail_adr(b_fadr), .fail_data(b_fdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkA(input string tag, input logic [5:0] flags, input int m, input int c);
        checkOutput({"A.", tag, ".flags"}, 64'({a_busy, a_done, a_pass, a_fail, a_code}), 64'(flags));
        checkOutput({"A.", tag, ".match"}, 64'(a_match), 64'(m));
        checkOutput({"A.", tag, ".cycles"}, 64'(a_cycles), 64'(c));
    endtask

    task automatic checkB(input string tag, input logic [5:0] flags, input int m, input int c);
        checkOutput({"B.", tag, ".flags"}, 64'({b_busy, b_done, b_pass, b_fail, b_code}), 64'(flags));
        checkOutput({"B.", tag, ".match"}, 64'(b_match), 64'(m));
        checkOutput({"B.", tag, ".cycles"}, 64'(b_cycles), 64'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] data);
        bus_if.mem_write  = mw;
        bus_if.data_adr   = adr;
        bus_if.write_data = data;
        tick();
        bus_if.mem_write  = 1'b0;
    endtask

    task automatic loadEntry(input logic [2:0] idx, input logic [31:0] adr, input logic [31:0] data);
        exp_we   = 1'b1;
        exp_idx  = idx;
        exp_adr  = adr;
        exp_data = data;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic startRun(input logic [3:0] n);
        n_exp = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        exp_we = 1'b0; exp_idx = '0; exp_adr = '0; exp_data = '0;
        n_exp = '0; start = 1'b0; clear = 1'b0;
        bus_if.mem_write = 1'b0; bus_if.data_adr = '0; bus_if.write_data = '0;
        idle(2);
        reset_n = 1'b1;
        tick();
        checkA("reset", F_IDLE, 0, 0);
        checkOutput("reset.fail_adr", 64'(a_fadr), 64'd0);

        // single expected write, matched on the sixth RUN edge
        loadEntry(3'd0, 32'd20, 32'd2);
        loadEntry(3'd1, 32'd24, 32'd7);
        startRun(4'd1);
        checkA("t1.run", F_RUN, 0, 0);
        idle(5);
        checkA("t1.c5", F_RUN, 0, 5);
        applyStimulus(1'b1, 32'd20, 32'd2);
        checkA("t1.pass", F_PASS, 1, 6);
        checkB("t1.pass", F_PASS, 1, 6);
        applyStimulus(1'b1, 32'd99, 32'd99);
        checkA("t1.hold", F_PASS, 1, 6);
        pulseClear();
        checkA("t1.clear", F_IDLE, 0, 0);

        // data mismatch on the second write
        startRun(4'd2);
        applyStimulus(1'b1, 32'd20, 32'd2);
        applyStimulus(1'b1, 32'd24, 32'd9);
        checkA("t2.fail", F_MISM, 1, 2);
        checkOutput("t2.fail_adr", 64'(a_fadr), 64'd24);
        checkOutput("t2.fail_data", 64'(a_fdata), 64'd9);
        checkB("t2.run", F_RUN, 1, 2);
        applyStimulus(1'b1, 32'd24, 32'd7);
        checkB("t2.pass", F_PASS, 2, 3);
        checkA("t2.sticky", F_MISM, 1, 2);
        pulseClear();

        // stray write first: strict fails, lenient ignores it
        startRun(4'd2);
        applyStimulus(1'b1, 32'd100, 32'd5);
        checkA("t3.fail", F_MISM, 0, 1);
        checkOutput("t3.fail_adr", 64'(a_fadr), 64'd100);
        checkOutput("t3.fail_data", 64'(a_fdata), 64'd5);
        checkB("t3.run", F_RUN, 0, 1);
        applyStimulus(1'b1, 32'd20, 32'd2);
        applyStimulus(1'b1, 32'd24, 32'd7);
        checkB("t3.pass", F_PASS, 2, 3);
        pulseClear();

        // timeout on the 16th RUN edge; clear during RUN has no effect
        startRun(4'd1);
        idle(14);
        pulseClear();
        checkA("t4.c15", F_RUN, 0, 15);
        idle(1);
        checkA("t4.tout", F_TOUT, 0, 16);
        checkB("t4.tout", F_TOUT, 0, 16);
        checkOutput("t4.fail_adr", 64'(a_fadr), 64'd0);
        checkOutput("t4.fail_data", 64'(a_fdata), 64'd0);
        pulseClear();

        // final match on the 16th RUN edge beats timeout
        startRun(4'd1);
        idle(15);
        applyStimulus(1'b1, 32'd20, 32'd2);
        checkA("t5.pass", F_PASS, 1, 16);
        checkB("t5.pass", F_PASS, 1, 16);
        pulseClear();

        // empty table passes immediately
        startRun(4'd0);
        checkA("t6.pass", F_PASS, 0, 0);
        pulseClear();

        // n_exp=12 clamps to 8; entry 7 loaded in the same cycle as start
        for (int i = 2; i < 7; i++) loadEntry(3'(i), 32'(100 + 4 * i), 32'(i));
        exp_we = 1'b1; exp_idx = 3'd7; exp_adr = 32'd128; exp_data = 32'd7;
        n_exp = 4'd12; start = 1'b1;
        tick();
        exp_we = 1'b0; start = 1'b0;
        applyStimulus(1'b1, 32'd20, 32'd2);
        applyStimulus(1'b1, 32'd24, 32'd7);
        for (int i = 2; i < 7; i++) applyStimulus(1'b1, 32'(100 + 4 * i), 32'(i));
        checkA("t7.run", F_RUN, 7, 7);
        applyStimulus(1'b1, 32'd128, 32'd7);
        checkA("t7.pass", F_PASS, 8, 8);
        checkB("t7.pass", F_PASS, 8, 8);
        pulseClear();

        // asynchronous reset mid-RUN clears outputs and the table
        startRun(4'd1);
        idle(2);
        reset_n = 1'b0;
        #1;
        checkA("t8.reset", F_IDLE, 0, 0);
        #2;
        reset_n = 1'b1;
        pulseClear();
        startRun(4'd1);
        applyStimulus(1'b1, 32'd0, 32'd0);
        checkA("t8.pass", F_PASS, 1, 1);
        checkB("t8.pass", F_PASS, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
